// File: rtl/frame_tx.sv
// Frame transmitter: pops one 140-bit entry and sends it as a framed run of
// 16-bit words (header, channel, data, CRC, tail), computing the CRC on an external unit.
module frame_tx #(
    parameter logic [15:0] IDLE_WORD  = 16'h0000,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         fifo_empty,
    output logic         fifo_r_enable,
    input  logic [139:0] data_from_fifo,
    output logic [15:0]  data_out,
    output logic         tx_active,
    output logic         frame_done,
    output logic         len_err,
    output logic [15:0]  crc_data,
    output logic [15:0]  crc_seed,
    input  logic [15:0]  crc_next
);
    localparam logic [15:0] HDR_WORD  = 16'hE0E0;
    localparam logic [15:0] TAIL_WORD = 16'h0E0E;
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, HDR1, HDR2, CHAN, DATA, CRC, TAIL1, TAIL2, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  shreg_q, shreg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    chan_q, chan_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   data_out_q, data_out_d;
    logic          fifo_r_enable_q, fifo_r_enable_d;
    logic          tx_active_q, tx_active_d;
    logic          frame_done_q, frame_done_d;
    logic          len_err_q, len_err_d;
    logic [15:0]   crc_data_q, crc_data_d;
    logic [15:0]   crc_seed_q, crc_seed_d;
    logic          emit_s;

    // Next-state and registered-output decode; each output describes the word shown in the following state.
    always_comb begin
        state_d         = state_q;
        shreg_d         = shreg_q;
        cnt_d           = cnt_q;
        chan_d          = chan_q;
        gap_d           = gap_q;
        data_out_d      = IDLE_WORD;
        fifo_r_enable_d = 1'b0;
        tx_active_d     = 1'b0;
        frame_done_d    = 1'b0;
        len_err_d       = 1'b0;
        crc_data_d      = 16'h0000;
        crc_seed_d      = crc_seed_q;
        emit_s          = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_r_enable_d = 1'b1;
                    state_d         = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                shreg_d = data_from_fifo[139:12];
                chan_d  = data_from_fifo[11:4];
                cnt_d   = data_from_fifo[3:0];
                if ((data_from_fifo[3:0] == 4'd0) || (data_from_fifo[3:0] > 4'd8)) begin
                    len_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    crc_seed_d  = 16'h0000;
                    data_out_d  = HDR_WORD;
                    tx_active_d = 1'b1;
                    state_d     = HDR1;
                end
            end
            HDR1: begin
                data_out_d  = HDR_WORD;
                tx_active_d = 1'b1;
                state_d     = HDR2;
            end
            HDR2: begin
                data_out_d  = {8'h00, chan_q};
                tx_active_d = 1'b1;
                state_d     = CHAN;
            end
            CHAN: begin
                emit_s  = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                // The word now on the link is crc_data_q; fold its CRC into the accumulator.
                crc_seed_d = crc_next;
                if (cnt_q == 4'd0) begin
                    data_out_d  = crc_next;
                    tx_active_d = 1'b1;
                    state_d     = CRC;
                end else begin
                    emit_s  = 1'b1;
                    state_d = DATA;
                end
            end
            CRC: begin
                data_out_d  = TAIL_WORD;
                tx_active_d = 1'b1;
                state_d     = TAIL1;
            end
            TAIL1: begin
                data_out_d   = TAIL_WORD;
                tx_active_d  = 1'b1;
                frame_done_d = 1'b1;
                state_d      = TAIL2;
            end
            TAIL2: begin
                gap_d   = 8'd0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + 8'd1;
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit_s) begin
            data_out_d  = shreg_q[127:112];
            crc_data_d  = shreg_q[127:112];
            tx_active_d = 1'b1;
            shreg_d     = {shreg_q[111:0], 16'h0000};
            cnt_d       = cnt_q - 4'd1;
        end else begin
            crc_data_d = 16'h0000;
        end
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            shreg_q         <= 128'd0;
            cnt_q           <= 4'd0;
            chan_q          <= 8'd0;
            gap_q           <= 8'd0;
            data_out_q      <= IDLE_WORD;
            fifo_r_enable_q <= 1'b0;
            tx_active_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            len_err_q       <= 1'b0;
            crc_data_q      <= 16'h0000;
            crc_seed_q      <= 16'h0000;
        end else begin
            state_q         <= state_d;
            shreg_q         <= shreg_d;
            cnt_q           <= cnt_d;
            chan_q          <= chan_d;
            gap_q           <= gap_d;
            data_out_q      <= data_out_d;
            fifo_r_enable_q <= fifo_r_enable_d;
            tx_active_q     <= tx_active_d;
            frame_done_q    <= frame_done_d;
            len_err_q       <= len_err_d;
            crc_data_q      <= crc_data_d;
            crc_seed_q      <= crc_seed_d;
        end
    end

    assign data_out      = data_out_q;
    assign fifo_r_enable = fifo_r_enable_q;
    assign tx_active     = tx_active_q;
    assign frame_done    = frame_done_q;
    assign len_err       = len_err_q;
    assign crc_data      = crc_data_q;
    assign crc_seed      = crc_seed_q;

endmodule

// File: tb/tb_frame_tx.sv
// Bench for frame_tx: show-ahead FIFO model, CRC-16/CCITT unit model and an
// expected-word scoreboard compared against the words logged while tx_active is high.
`timescale 1ns/1ps
module tb_frame_tx;
    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic         fifo_r_enable;
    logic [139:0] data_from_fifo;
    logic [15:0]  data_out;
    logic         tx_active;
    logic         frame_done;
    logic         len_err;
    logic [15:0]  crc_data;
    logic [15:0]  crc_seed;
    logic [15:0]  crc_next;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [139:0] fifo_q[$];
    int           fifo_n = 0;
    logic         force_empty = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] gdat_q[$];
    logic [15:0] gseed_q[$];
    int got_cyc[$];
    int done_cyc[$];
    int pop_cyc[$];
    int lerr_cyc[$];
    int idle_bad = 0;
    int lerr_bad = 0;

    frame_tx dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_r_enable  (fifo_r_enable),
        .data_from_fifo (data_from_fifo),
        .data_out       (data_out),
        .tx_active      (tx_active),
        .frame_done     (frame_done),
        .len_err        (len_err),
        .crc_data       (crc_data),
        .crc_seed       (crc_seed),
        .crc_next       (crc_next)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] crc16(input logic [15:0] seed, input logic [15:0] d);
        logic [15:0] c;
        c = seed ^ d;
        for (int b = 0; b < 16; b++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    assign crc_next   = crc16(crc_seed, crc_data);
    assign fifo_empty = (fifo_n == 0) || force_empty;

    always @(posedge clk_in) cyc <= cyc + 1;

    // FIFO pop on the strobe (old value seen at the edge); head refreshed at negedge
    always @(posedge clk_in) begin
        if (fifo_r_enable && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            fifo_n = fifo_n - 1;
        end
    end

    always @(negedge clk_in) begin
        if (fifo_q.size() > 0) data_from_fifo = fifo_q[0];
    end

    // Output logger
    always @(negedge clk_in) begin
        if (tx_active) begin
            got_q.push_back(data_out);
            gdat_q.push_back(crc_data);
            gseed_q.push_back(crc_seed);
            got_cyc.push_back(cyc);
        end else if (data_out !== 16'h0000) begin
            idle_bad = idle_bad + 1;
        end
        if (frame_done) done_cyc.push_back(cyc);
        if (fifo_r_enable) pop_cyc.push_back(cyc);
        if (len_err) begin
            lerr_cyc.push_back(cyc);
            if (data_out !== 16'h0000) lerr_bad = lerr_bad + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); gdat_q.delete(); gseed_q.delete();
        got_cyc.delete(); done_cyc.delete(); pop_cyc.delete(); lerr_cyc.delete();
        idle_bad = 0;
        lerr_bad = 0;
    endtask

    // Queue an entry and push the frame it should produce onto the scoreboard
    task automatic push_entry(input logic [127:0] d, input logic [7:0] ch,
                              input logic [3:0] len, input bit expect_frame);
        logic [15:0] acc;
        logic [15:0] w;
        fifo_q.push_back({d, ch, len});
        fifo_n = fifo_n + 1;
        if (fifo_q.size() == 1) data_from_fifo = fifo_q[0];
        if (expect_frame) begin
            exp_q.push_back(16'hE0E0);
            exp_q.push_back(16'hE0E0);
            exp_q.push_back({8'h00, ch});
            acc = 16'h0000;
            for (int k = 0; k < int'(len); k++) begin
                w = d[127 - 16*k -: 16];
                exp_q.push_back(w);
                acc = crc16(acc, w);
            end
            exp_q.push_back(acc);
            exp_q.push_back(16'h0E0E);
            exp_q.push_back(16'h0E0E);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({data_out, fifo_r_enable, tx_active, frame_done, len_err, crc_data, crc_seed} !== 52'd0) begin
            errors++;
            $display("FAIL reset_values got data_out=%h en=%b act=%b done=%b lerr=%b crc_data=%h crc_seed=%h, want all zero",
                     data_out, fifo_r_enable, tx_active, frame_done, len_err, crc_data, crc_seed);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_len1();
        logic [15:0] e;
        logic [15:0] g;
        clear_logs();
        push_entry({16'hA5A5, 112'hDEAD_BEEF_1234_5678_9ABC_DEF0_1357}, 8'h05, 4'd1, 1'b1);
        for (int i = 0; i < 200 && done_cyc.size() < 1; i++) tick(1);
        tick(4);
        checks++;
        if (got_cyc.size() != 7 || done_cyc.size() != 1 || pop_cyc.size() != 1) begin
            errors++;
            $display("FAIL len1_shape got words=%0d done=%0d pops=%0d, want 7/1/1",
                     got_cyc.size(), done_cyc.size(), pop_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != got_cyc[6]) begin
                errors++;
                $display("FAIL len1_done_pos got cycle %0d, want %0d", done_cyc[0], got_cyc[6]);
            end
            checks++;
            if (got_cyc[6] - got_cyc[0] != 6) begin
                errors++;
                $display("FAIL len1_active_span got %0d, want 6", got_cyc[6] - got_cyc[0]);
            end
            checks++;
            if (got_cyc[0] - pop_cyc[0] != 1) begin
                errors++;
                $display("FAIL len1_pop_to_hdr got %0d, want 1", got_cyc[0] - pop_cyc[0]);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL len1_word got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_len8();
        logic [127:0] d;
        logic [15:0]  acc;
        logic [15:0]  e;
        logic [15:0]  g;
        clear_logs();
        for (int k = 0; k < 8; k++) d[127 - 16*k -: 16] = 16'(k + 1);
        push_entry(d, 8'hFF, 4'd8, 1'b1);
        for (int i = 0; i < 200 && done_cyc.size() < 1; i++) tick(1);
        tick(4);
        checks++;
        if (got_q.size() != 14) begin
            errors++;
            $display("FAIL len8_count got %0d words, want 14", got_q.size());
        end else begin
            acc = 16'h0000;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (gdat_q[3+k] !== 16'(k + 1) || gseed_q[3+k] !== acc) begin
                    errors++;
                    $display("FAIL len8_crc_io word %0d got data=%h seed=%h, want data=%h seed=%h",
                             k, gdat_q[3+k], gseed_q[3+k], 16'(k + 1), acc);
                end
                acc = crc16(acc, 16'(k + 1));
            end
            checks++;
            if (gdat_q[11] !== 16'h0000 || gseed_q[11] !== acc || got_q[11] !== acc) begin
                errors++;
                $display("FAIL len8_crc_word got word=%h seed=%h data=%h, want word=seed=%h data=0000",
                         got_q[11], gseed_q[11], gdat_q[11], acc);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL len8_word got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_len_err();
        clear_logs();
        push_entry({16'hE0E0, 112'h0}, 8'h11, 4'd0, 1'b0);
        push_entry({16'hE0E0, 112'h5}, 8'h22, 4'd9, 1'b0);
        tick(30);
        checks++;
        if (lerr_cyc.size() != 2 || pop_cyc.size() != 2) begin
            errors++;
            $display("FAIL lenerr_counts got len_err=%0d pops=%0d, want 2/2", lerr_cyc.size(), pop_cyc.size());
        end else begin
            checks++;
            if (lerr_cyc[0] - pop_cyc[0] != 1 || pop_cyc[1] - pop_cyc[0] != 2) begin
                errors++;
                $display("FAIL lenerr_timing got pop->err=%0d pop->pop=%0d, want 1/2",
                         lerr_cyc[0] - pop_cyc[0], pop_cyc[1] - pop_cyc[0]);
            end
        end
        checks++;
        if (got_q.size() != 0 || idle_bad != 0 || lerr_bad != 0) begin
            errors++;
            $display("FAIL lenerr_silent got words=%0d idle_bad=%0d lerr_bad=%0d, want 0/0/0",
                     got_q.size(), idle_bad, lerr_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        logic [15:0] g;
        clear_logs();
        push_entry({16'h1111, 16'h2222, 96'hFFFF}, 8'h3C, 4'd2, 1'b1);
        push_entry({16'h3333, 16'h4444, 16'h5555, 80'h0}, 8'hC3, 4'd3, 1'b1);
        for (int i = 0; i < 300 && done_cyc.size() < 2; i++) tick(1);
        tick(4);
        checks++;
        if (got_cyc.size() != 17 || done_cyc.size() != 2 || pop_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_shape got words=%0d done=%0d pops=%0d, want 17/2/2",
                     got_cyc.size(), done_cyc.size(), pop_cyc.size());
        end else begin
            checks++;
            if (got_cyc[8] - done_cyc[0] != 5) begin
                errors++;
                $display("FAIL b2b_gap got %0d, want 5", got_cyc[8] - done_cyc[0]);
            end
            checks++;
            if (pop_cyc[1] - pop_cyc[0] != 12) begin
                errors++;
                $display("FAIL b2b_period got %0d, want 12", pop_cyc[1] - pop_cyc[0]);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_word got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] e;
        logic [15:0] g;
        int tails;
        clear_logs();
        push_entry({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 64'h0}, 8'h44, 4'd4, 1'b0);
        for (int i = 0; i < 200 && got_q.size() < 5; i++) tick(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 16'h0000 || tx_active !== 1'b0 || crc_data !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async got data_out=%h act=%b crc_data=%h, want 0000/0/0000",
                     data_out, tx_active, crc_data);
        end
        tick(2);
        rst_n = 1'b1;
        tick(12);
        tails = 0;
        foreach (got_q[i]) if (got_q[i] === 16'h0E0E) tails++;
        checks++;
        if (got_q.size() != 5 || tails != 0) begin
            errors++;
            $display("FAIL rst_abandon got words=%0d tails=%0d, want 5/0", got_q.size(), tails);
        end
        clear_logs();
        push_entry({16'h0F0F, 16'hF0F0, 16'h1234, 16'h8001, 64'h0}, 8'h99, 4'd4, 1'b1);
        for (int i = 0; i < 200 && done_cyc.size() < 1; i++) tick(1);
        tick(4);
        checks++;
        if (got_q.size() != 10) begin
            errors++;
            $display("FAIL rst_recover_count got %0d words, want 10", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rst_recover_word got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_empty_glitch();
        logic [15:0] e;
        logic [15:0] g;
        clear_logs();
        push_entry({16'h6666, 16'h7777, 96'h0}, 8'h0A, 4'd2, 1'b1);
        for (int i = 0; i < 200 && got_q.size() < 3; i++) tick(1);
        push_entry({16'h8888, 112'h0}, 8'h0B, 4'd1, 1'b1);
        force_empty = 1'b1;
        tick(1);
        force_empty = 1'b0;
        for (int i = 0; i < 300 && done_cyc.size() < 2; i++) tick(1);
        tick(4);
        checks++;
        if (pop_cyc.size() != 2 || done_cyc.size() != 2) begin
            errors++;
            $display("FAIL glitch_pops got pops=%0d done=%0d, want 2/2", pop_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[1] - done_cyc[0] != 4) begin
                errors++;
                $display("FAIL glitch_second_pop got %0d, want 4", pop_cyc[1] - done_cyc[0]);
            end
        end
        checks++;
        if (got_q.size() != 15) begin
            errors++;
            $display("FAIL glitch_count got %0d words, want 15", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL glitch_word got %h, want %h", g, e);
            end
        end
    endtask

    initial begin
        data_from_fifo = 140'd0;
        test_reset();
        test_len1();
        test_len8();
        test_len_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
